// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction prefetch stage. Runs ahead of execution, fetching sequential
// instruction words from a word-addressed memory over a req/ack handshake,
// and buffers up to DEPTH {pc, word} pairs in a FIFO that feeds the
// instruction register. A taken branch flushes the queue and redirects
// fetch; a request already outstanding at that point is completed and its
// data discarded.
//
// Optional feature macro: IFQ_BYPASS_EN
//   Defined   : an acked word arriving while the FIFO is empty is presented
//               on ir_* in the same cycle, and is not queued if ir_take is
//               high in that cycle.
//   Undefined : ir_* come from registered storage only (ack in cycle N,
//               ir_valid in cycle N+1).
//
// Ports:
//   CLK        in   rising-edge clock
//   RST_F      in   asynchronous active-low reset
//   mem_req    out  fetch request, held until mem_ack
//   mem_addr   out  fetch word address, stable while mem_req is high
//   mem_ack    in   one-cycle pulse, mem_data valid in the same cycle
//   mem_data   in   fetched instruction word
//   ir_valid   out  head entry valid
//   ir_data    out  head instruction word (0 when empty)
//   ir_pc      out  address of head instruction (0 when empty)
//   ir_take    in   consumer pops the head this cycle
//   br_taken   in   flush and redirect, single-cycle pulse
//   br_addr    in   redirect target
//   ifq_count  out  current FIFO occupancy
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST_F,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    input  logic                     mem_ack,
    input  logic [DW-1:0]            mem_data,
    output logic                     ir_valid,
    output logic [DW-1:0]            ir_data,
    output logic [AW-1:0]            ir_pc,
    input  logic                     ir_take,
    input  logic                     br_taken,
    input  logic [AW-1:0]            br_addr,
    output logic [$clog2(DEPTH):0]   ifq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   fpc;

    logic [DW-1:0]   data_mem [DEPTH];
    logic [AW-1:0]   pc_mem   [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            fifo_valid;
    logic            ack_ok;
    logic            bypass_hit;
    logic            bypass_take;
    logic            push;
    logic            pop;

    // -----------------------------------------------------------------------
    // Push / pop qualification
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_valid = (count != '0);
        // An ack only delivers a usable word in REQ and when no flush is
        // happening in the same cycle.
        ack_ok     = (state == REQ) && mem_ack && !br_taken;
`ifdef IFQ_BYPASS_EN
        bypass_hit  = ack_ok && !fifo_valid;
        bypass_take = bypass_hit && ir_take;
`else
        bypass_hit  = 1'b0;
        bypass_take = 1'b0;
`endif
        // A word consumed straight off the bypass is never written.
        push      = ack_ok && !bypass_take;
        pop       = ir_take && fifo_valid && !br_taken;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // -----------------------------------------------------------------------
    // Head presentation
    // -----------------------------------------------------------------------
    always_comb begin
        ir_valid = fifo_valid || bypass_hit;
        ir_data  = '0;
        ir_pc    = '0;
        if (fifo_valid) begin
            ir_data = data_mem[rd_ptr];
            ir_pc   = pc_mem[rd_ptr];
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass_hit) begin
            ir_data = mem_data;
            ir_pc   = mem_addr;
        end
`endif
    end

    assign ifq_count = count;

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (br_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_data;
            pc_mem[wr_ptr]   <= fpc;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch FSM. mem_req / mem_addr are registered; in REQ, mem_addr always
    // equals fpc, so fpc is the pc recorded with each pushed word.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state    <= IDLE;
            fpc      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_taken) begin
                        fpc <= br_addr;
                    end else if (count < CW'(DEPTH)) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fpc;
                    end
                end

                REQ: begin
                    if (br_taken) begin
                        fpc <= br_addr;
                        if (mem_ack) begin
                            // Request retired this cycle: refetch at once.
                            mem_addr <= br_addr;
                        end else begin
                            // Outstanding request must still complete.
                            state <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        fpc <= fpc + AW'(1);
                        if (count_nxt < CW'(DEPTH)) begin
                            mem_addr <= fpc + AW'(1);
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end

                DISCARD: begin
                    if (br_taken)
                        fpc <= br_addr;
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Self-checking bench for ifetch_queue. A behavioural memory (configurable
// ack latency, word = addr + 32'h1000 unless overridden) answers requests.
// Every cycle the bench tracks the expected fetch address and a queue of
// expected {pc, word} entries, and compares occupancy, head and ack address
// against it. A table of per-cycle vectors covers start-up and the full /
// refill case; hand-written sequences cover flush, wrap and bypass.
// Honours IFQ_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

    logic        CLK;
    logic        RST_F;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_take;
    logic        br_taken;
    logic [15:0] br_addr;
    logic [2:0]  ifq_count;

    ifetch_queue #(.DEPTH(4), .AW(16), .DW(32)) dut (
        .CLK       (CLK),
        .RST_F     (RST_F),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .ir_valid  (ir_valid),
        .ir_data   (ir_data),
        .ir_pc     (ir_pc),
        .ir_take   (ir_take),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .ifq_count (ifq_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        take;
        logic        br;
        logic [15:0] ba;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic [2:0]  exp_cnt;
    } vec_t;

    ent_t        sb[$];
    vec_t        vt[9];
    int          checks;
    int          errors;
    int          mem_lat;
    int          wait_cnt;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic [15:0] exp_fpc;
    logic        discard_armed;
    logic        got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs and the memory at negedge, sample at +1,
    // compare against the expected queue, then advance the model.
    task automatic step(input logic take, input logic br, input logic [15:0] ba);
        logic        cand;
        logic        was_empty;
        logic [31:0] ed;
        @(negedge CLK);
        ir_take  = take;
        br_taken = br;
        br_addr  = ba;
        if (mem_req) begin
            if (wait_cnt >= mem_lat) begin
                mem_ack  = 1'b1;
                mem_data = ovr_en ? ovr_data : 32'h1000 + {16'h0, mem_addr};
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        #1;
        ed        = ovr_en ? ovr_data : 32'h1000 + {16'h0, exp_fpc};
        cand      = mem_ack && !br && !discard_armed;
        was_empty = (sb.size() == 0);

        chk("count", 32'(ifq_count), 32'(sb.size()));
        if (!was_empty) begin
            chk("valid", 32'(ir_valid), 32'd1);
            chk("head_pc", 32'(ir_pc), 32'(sb[0].pc));
            chk("head_data", ir_data, sb[0].data);
        end else begin
`ifdef IFQ_BYPASS_EN
            chk("valid", 32'(ir_valid), 32'(cand));
            if (cand) begin
                chk("byp_pc", 32'(ir_pc), 32'(exp_fpc));
                chk("byp_data", ir_data, ed);
            end
`else
            chk("valid", 32'(ir_valid), 32'd0);
`endif
        end
        if (cand)
            chk("fetch_addr", 32'(mem_addr), 32'(exp_fpc));

        if (br) begin
            sb.delete();
            exp_fpc = ba;
            if (mem_ack)
                discard_armed = 1'b0;
            else if (mem_req)
                discard_armed = 1'b1;
        end else begin
            if (take && !was_empty)
                void'(sb.pop_front());
            if (mem_ack && discard_armed) begin
                discard_armed = 1'b0;
            end else if (cand) begin
`ifdef IFQ_BYPASS_EN
                if (!(take && was_empty))
                    sb.push_back('{pc: exp_fpc, data: ed});
`else
                sb.push_back('{pc: exp_fpc, data: ed});
`endif
                exp_fpc = exp_fpc + 16'd1;
            end
        end
        if (mem_ack)
            ovr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // take, br, br_addr, exp_req, exp_addr, exp_cnt  (cycles after reset)
        vt[0] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 3'd0};
        vt[1] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 3'd1};
        vt[2] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 3'd2};
        vt[3] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 3'd3};
        vt[4] = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 3'd4};
        vt[5] = '{1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 3'd4};
        vt[6] = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 3'd3};
        vt[7] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0004, 3'd3};
        vt[8] = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 3'd4};

        checks = 0; errors = 0;
        mem_lat = 0; wait_cnt = 0;
        ovr_en = 1'b0; ovr_data = '0;
        exp_fpc = '0; discard_armed = 1'b0;
        RST_F = 1'b0; mem_ack = 1'b0; mem_data = '0;
        ir_take = 1'b0; br_taken = 1'b0; br_addr = '0;

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_data", ir_data, 32'd0);
        chk("rst_pc", 32'(ir_pc), 32'd0);
        chk("rst_count", 32'(ifq_count), 32'd0);
        RST_F = 1'b1;

        // Start-up fill and single-pop refill
        for (int i = 0; i < 9; i++) begin
            step(vt[i].take, vt[i].br, vt[i].ba);
            chk("vec_req", 32'(mem_req), 32'(vt[i].exp_req));
            if (vt[i].exp_req)
                chk("vec_addr", 32'(mem_addr), 32'(vt[i].exp_addr));
            chk("vec_count", 32'(ifq_count), 32'(vt[i].exp_cnt));
            if (i == 4) begin
                chk("full_head_data", ir_data, 32'h0000_1000);
                chk("full_head_pc", 32'(ir_pc), 32'h0);
            end
            if (i == 6) begin
                chk("pop_head_data", ir_data, 32'h0000_1001);
                chk("pop_head_pc", 32'(ir_pc), 32'h1);
            end
        end

        // Flush while a request is outstanding
        mem_lat = 3;
        step(1'b1, 1'b0, 16'h0);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = mem_req;
        end
        chk("flush_pre_req", 32'(got), 32'd1);
        step(1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 16'h0);
        chk("flush_valid", 32'(ir_valid), 32'd0);
        chk("flush_count", 32'(ifq_count), 32'd0);
        chk("discard_req_held", 32'(mem_req), 32'd1);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = !mem_req;
        end
        chk("discard_done", 32'(got), 32'd1);
        mem_lat = 0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = mem_req;
        end
        chk("redirect_req", 32'(got), 32'd1);
        chk("redirect_addr", 32'(mem_addr), 32'h0040);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = ir_valid;
        end
        chk("redirect_valid", 32'(got), 32'd1);
        chk("redirect_pc", 32'(ir_pc), 32'h0040);

        // Branch coincident with ack and take
        step(1'b1, 1'b1, 16'h0080);
        chk("coinc_ack", 32'(mem_ack), 32'd1);
        step(1'b0, 1'b0, 16'h0);
        chk("coinc_count", 32'(ifq_count), 32'd0);
        chk("coinc_req", 32'(mem_req), 32'd1);
        chk("coinc_addr", 32'(mem_addr), 32'h0080);

        // Fetch address wrap
        step(1'b0, 1'b1, 16'hFFFF);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = (ifq_count >= 3'd2);
        end
        chk("wrap_fill", 32'(got), 32'd1);
        chk("wrap_pc0", 32'(ir_pc), 32'hFFFF);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("wrap_pc1", 32'(ir_pc), 32'h0000);
        chk("wrap_data1", ir_data, 32'h0000_1000);

        // Empty queue, ack with take in the same cycle
        step(1'b0, 1'b1, 16'h0100);
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_0001;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b1, 1'b0, 16'h0);
            got = mem_ack;
        end
        chk("byp_ack_seen", 32'(got), 32'd1);
`ifdef IFQ_BYPASS_EN
        chk("byp_same_valid", 32'(ir_valid), 32'd1);
        chk("byp_same_data", ir_data, 32'hDEAD_0001);
        step(1'b0, 1'b0, 16'h0);
        chk("byp_count", 32'(ifq_count), 32'd0);
`else
        chk("nobyp_same_valid", 32'(ir_valid), 32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("nobyp_next_valid", 32'(ir_valid), 32'd1);
        chk("nobyp_next_data", ir_data, 32'hDEAD_0001);
        chk("nobyp_count", 32'(ifq_count), 32'd1);
`endif

        // Reset in the middle of an outstanding request
        mem_lat = 5;
        for (int n = 0; n < 4; n++)
            step(1'b1, 1'b0, 16'h0);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            step(1'b0, 1'b0, 16'h0);
            got = mem_req;
        end
        chk("midrst_pre_req", 32'(got), 32'd1);
        RST_F = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_valid", 32'(ir_valid), 32'd0);
        chk("midrst_count", 32'(ifq_count), 32'd0);
        sb.delete();
        exp_fpc = '0;
        discard_armed = 1'b0;
        wait_cnt = 0;
        mem_ack = 1'b0;
        mem_lat = 0;
        @(negedge CLK);
        RST_F = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", 32'(mem_addr), 32'd0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("restart_pc", 32'(ir_pc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction prefetch stage between the instruction memory and the decode/control path.
- Runs ahead of execution, fetching sequential instruction words from a word-addressed memory over a req/ack handshake, and buffers up to DEPTH words with their addresses in a FIFO.
- Feeds the instruction register / ctrl opcode fields.
- A taken branch flushes the queue and redirects fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, 2..16
- AW, 16, instruction address width (matches PC width)
- DW, 32, instruction word width

Ports:
- CLK  input  1  clock, rising edge
- RST_F  input  1  asynchronous active-low reset
- mem_req  output  1  fetch request, held until mem_ack
- mem_addr  output  AW  fetch word address, stable while mem_req high
- mem_ack  input  1  one-cycle pulse; mem_data valid in same cycle
- mem_data  input  DW  fetched instruction word
- ir_valid  output  1  head entry valid
- ir_data  output  DW  head instruction word
- ir_pc  output  AW  address of head instruction
- ir_take  input  1  consumer pops head this cycle
- br_taken  input  1  flush and redirect, single-cycle pulse
- br_addr  input  AW  redirect target
- ifq_count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (RST_F low, asynchronous): state=IDLE, fpc=0, FIFO empty, count=0. Outputs: mem_req=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, ifq_count=0.
- Reset asserted mid-transaction abandons the request; the memory must tolerate a dropped request.
- FSM states: IDLE, REQ, DISCARD. mem_req=1 in REQ and DISCARD only. mem_addr is a register loaded on entry to REQ.
- IDLE -> REQ when count<DEPTH and !br_taken; mem_addr<=fpc.
  - First mem_req rises on the first CLK edge after RST_F deasserts.
- REQ, mem_ack, !br_taken:
  - push {fpc, mem_data}; fpc<=fpc+1 (wraps 16'hFFFF->0).
  - If post-push/post-pop count<DEPTH: stay REQ with mem_addr<=fpc+1 (back-to-back, 1 word/cycle with zero-wait memory).
  - Otherwise go to IDLE.
- REQ, br_taken (with or without ack):
  - clear FIFO; fpc<=br_addr.
  - If ack in the same cycle: data dropped, go to REQ with mem_addr<=br_addr.
  - Else go to DISCARD.
- DISCARD: hold mem_req and mem_addr. On mem_ack, drop data and go to IDLE.
  - br_taken in DISCARD: clear FIFO again, fpc<=br_addr (last wins).
- IDLE, br_taken: clear FIFO, fpc<=br_addr, stay IDLE; REQ is issued next cycle.
- mem_ack outside REQ/DISCARD is ignored.
- Pop:
  - ir_take && ir_valid removes head.
  - ir_take with ir_valid=0 is ignored.
  - br_taken overrides ir_take.
- Simultaneous push and pop: count unchanged. Push when full cannot occur, because REQ is entered only with space and pops only free space.
- ir_valid = (count!=0). ir_data/ir_pc are driven from registered storage at the read pointer and are 0 when empty.
- Pointers wrap modulo DEPTH.
- Latency without bypass: ack in cycle N -> ir_valid in cycle N+1.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined and the FIFO is empty with a valid, non-flushed ack in REQ:
  - ir_valid=1, ir_data=mem_data, ir_pc=mem_addr in the same cycle (combinational bypass).
  - If ir_take is also high, the word is consumed and not written to the FIFO; count stays 0.
- When undefined: no combinational path from mem_* to ir_*; one-cycle latency as above.

Test Plan:
- Reset release, zero-wait memory returning word = addr+32'h1000, ir_take=0 -> mem_addr 0,1,2,3 on consecutive acks; count reaches 4; mem_req drops; ir_data=32'h1000, ir_pc=0.
- Full queue, pulse ir_take once -> head becomes 32'h1001/pc 1; next cycle REQ issued for addr 4; count returns to 4.
- Flush while request outstanding (ack delayed 3 cycles), br_taken with br_addr=16'h0040 -> FIFO cleared, ir_valid=0; late ack data discarded; next mem_addr=16'h0040; first ir_pc=16'h0040.
- br_taken coincident with mem_ack and ir_take -> ack data not queued; count=0; next mem_addr=br_addr.
- fpc at 16'hFFFF -> pushed entries have ir_pc FFFF then 0000.
- With IFQ_BYPASS_EN, empty queue, ack of 32'hDEAD0001 with ir_take=1 -> ir_valid=1 and ir_data=32'hDEAD0001 in the ack cycle; ifq_count stays 0. Without the macro, ir_valid rises one cycle later.
